// File: rtl/dbus_arbiter.sv
// Two-master arbiter onto one synchronous single-port memory: single-cycle writes, two-cycle reads.
// Round-robin or fixed priority (PRIO_MODE); requesters are held off by withholding their ready.
module dbus_arbiter #(
    parameter int PRIO_MODE = 0
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic [31:0] m0_addr,
    input  logic        m0_wr_req,
    output logic        m0_wr_ready,
    input  logic [3:0]  m0_wr_be,
    input  logic [31:0] m0_wr_data,
    input  logic        m0_rd_req,
    output logic        m0_rd_ready,
    output logic [31:0] m0_rd_data,
    input  logic [31:0] m1_addr,
    input  logic        m1_wr_req,
    output logic        m1_wr_ready,
    input  logic [3:0]  m1_wr_be,
    input  logic [31:0] m1_wr_data,
    input  logic        m1_rd_req,
    output logic        m1_rd_ready,
    output logic [31:0] m1_rd_data,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        cnt_clr,
    output logic [15:0] conflict_cnt
);

    typedef enum logic {IDLE = 1'b0, RD_DATA = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        last_gnt_q, last_gnt_d;
    logic        rd_owner_q, rd_owner_d;
    logic [15:0] cnt_q, cnt_d;

    logic req0, req1, gnt_vld, gnt_idx, gnt_wr, wait0, wait1;

    assign req0 = m0_wr_req | m0_rd_req;
    assign req1 = m1_wr_req | m1_rd_req;

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        rd_owner_d  = rd_owner_q;
        gnt_vld     = 1'b0;
        gnt_idx     = 1'b0;
        gnt_wr      = 1'b0;
        m0_wr_ready = 1'b0;
        m1_wr_ready = 1'b0;
        m0_rd_ready = 1'b0;
        m1_rd_ready = 1'b0;
        m0_rd_data  = 32'h0;
        m1_rd_data  = 32'h0;
        mem_cs      = 1'b0;
        mem_we      = 1'b0;
        mem_be      = 4'h0;
        mem_addr    = 32'h0;
        mem_wdata   = 32'h0;

        // Outputs are gated by rstb so nothing leaks out while reset is held.
        if (rstb) begin
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt_vld = 1'b1;
                        if (req0 && req1)
                            gnt_idx = (PRIO_MODE != 0) ? 1'b0 : ~last_gnt_q;
                        else
                            gnt_idx = req1;
                        gnt_wr     = gnt_idx ? m1_wr_req : m0_wr_req;
                        last_gnt_d = gnt_idx;
                        mem_cs     = 1'b1;
                        mem_addr   = gnt_idx ? m1_addr : m0_addr;
                        if (gnt_wr) begin
                            mem_we      = 1'b1;
                            mem_be      = gnt_idx ? m1_wr_be : m0_wr_be;
                            mem_wdata   = gnt_idx ? m1_wr_data : m0_wr_data;
                            m0_wr_ready = ~gnt_idx;
                            m1_wr_ready = gnt_idx;
                        end else begin
                            rd_owner_d = gnt_idx;
                            state_d    = RD_DATA;
                        end
                    end
                end
                RD_DATA: begin
                    // Completes even if the owner has dropped its request.
                    state_d = IDLE;
                    if (rd_owner_q) begin
                        m1_rd_ready = 1'b1;
                        m1_rd_data  = mem_rdata;
                    end else begin
                        m0_rd_ready = 1'b1;
                        m0_rd_data  = mem_rdata;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign wait0 = req0 && !(gnt_vld && !gnt_idx) && !(state_q == RD_DATA && !rd_owner_q);
    assign wait1 = req1 && !(gnt_vld &&  gnt_idx) && !(state_q == RD_DATA &&  rd_owner_q);

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr)
            cnt_d = 16'h0;
        else if ((wait0 || wait1) && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
    end

    assign conflict_cnt = cnt_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            rd_owner_q <= 1'b0;
            cnt_q      <= 16'h0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            rd_owner_q <= rd_owner_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule
